// File: rtl/pll_nco_clock_enables_if.sv
// Configuration bus for the NCO clock-enable generator: per-channel increment writes
// and the per-channel "retune pending" status flags.
interface pll_nco_clock_enables_if #(
  parameter int CHANNELS = 3,
  parameter int ACC_W    = 24
);
  localparam int AW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                cfg_we;
  logic [AW-1:0]       cfg_addr;
  logic [ACC_W-1:0]    cfg_data;
  logic [CHANNELS-1:0] cfg_pending;

  modport master (output cfg_we, cfg_addr, cfg_data, input cfg_pending);
  modport slave  (input cfg_we, cfg_addr, cfg_data, output cfg_pending);
endinterface

// File: rtl/pll_nco_clock_enables.sv
// Multi-channel phase-accumulator clock-enable generator, gated until PLL lock has settled.
// Retunes are staged and applied on the channel's next wrap so the period never glitches.
module pll_nco_clock_enables #(
  parameter int CHANNELS      = 3,
  parameter int ACC_W         = 24,
  parameter int SETTLE_CYCLES = 1024,
  parameter logic [CHANNELS*ACC_W-1:0] INIT_INC = {CHANNELS{ACC_W'(24'h200000)}}
) (
  input  logic                    clock_in,
  input  logic                    reset,
  input  logic                    pll_locked,
  pll_nco_clock_enables_if.slave  cfg,
  output logic                    running,
  output logic [CHANNELS-1:0]     ce,
  output logic [CHANNELS-1:0]     sq
);
  localparam int AW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = $clog2(SETTLE_CYCLES);

  typedef enum logic [1:0] {S_OFF, S_SETTLE, S_RUN} state_t;

  logic             lock_meta_reg;
  logic             lock_sync_reg;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      lock_meta_reg <= 1'b0;
      lock_sync_reg <= 1'b0;
    end else begin
      lock_meta_reg <= pll_locked;
      lock_sync_reg <= lock_meta_reg;
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_reg <= S_OFF;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // RUN is entered on the edge where the settle counter lands on SETTLE_CYCLES-1.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_OFF: begin
        cnt_next = '0;
        if (lock_sync_reg) state_next = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(SETTLE_CYCLES - 2)) state_next = S_RUN;
      end
      S_RUN: begin
        cnt_next = cnt_reg;
      end
      default: begin
        state_next = S_OFF;
        cnt_next   = '0;
      end
    endcase
    if (!lock_sync_reg) begin
      state_next = S_OFF;
      cnt_next   = '0;
    end
  end

  assign running = (state_reg == S_RUN);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] inc_reg;
    logic [ACC_W-1:0] staged_reg;
    logic             ce_reg;
    logic             pending_reg;
    logic [ACC_W:0]   sum;
    logic             wr_hit;
    logic             take_staged;

    assign sum    = {1'b0, acc_reg} + {1'b0, inc_reg};
    assign wr_hit = cfg.cfg_we && (cfg.cfg_addr == AW'(gi));
    // A stopped channel (inc=0) never wraps, so its staged value is taken at once.
    assign take_staged = running && lock_sync_reg && pending_reg &&
                         (sum[ACC_W] || (inc_reg == '0));

    always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
        acc_reg     <= '0;
        ce_reg      <= 1'b0;
        inc_reg     <= INIT_INC[gi*ACC_W +: ACC_W];
        staged_reg  <= '0;
        pending_reg <= 1'b0;
      end else begin
        if (!lock_sync_reg) begin
          acc_reg <= '0;
          ce_reg  <= 1'b0;
        end else if (running) begin
          acc_reg <= sum[ACC_W-1:0];
          ce_reg  <= sum[ACC_W];
        end
        if (take_staged) begin
          inc_reg     <= staged_reg;
          pending_reg <= 1'b0;
        end
        // A write on the wrap edge lands after the swap and stays pending.
        if (wr_hit) begin
          staged_reg  <= cfg.cfg_data;
          pending_reg <= 1'b1;
        end
      end
    end

    assign ce[gi]              = ce_reg;
    assign sq[gi]              = acc_reg[ACC_W-1];
    assign cfg.cfg_pending[gi] = pending_reg;
  end
endmodule

// File: tb/tb_pll_nco_clock_enables.sv
// Directed bench for the NCO clock-enable generator: settle timing, rates, retune,
// ignored writes, stopped channels, lock loss and reset with a pending write.
module tb_pll_nco_clock_enables;
  logic       clock_in = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       running;
  logic [2:0] ce;
  logic [2:0] sq;

  int errors = 0;
  int checks = 0;
  int adv    = 0;

  pll_nco_clock_enables_if #(.CHANNELS(3), .ACC_W(24)) cfg_bus ();

  pll_nco_clock_enables #(
    .CHANNELS(3), .ACC_W(24), .SETTLE_CYCLES(16), .INIT_INC({3{24'h200000}})
  ) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .pll_locked(pll_locked),
    .cfg       (cfg_bus),
    .running   (running),
    .ce        (ce),
    .sq        (sq)
  );

  always #5 clock_in = ~clock_in;

  task automatic tick();
    @(posedge clock_in);
    #1;
    adv++;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [23:0] d);
    cfg_bus.cfg_we   = 1'b1;
    cfg_bus.cfg_addr = a;
    cfg_bus.cfg_data = d;
    tick();
    cfg_bus.cfg_we   = 1'b0;
    $display("write addr=%0d data=%06h adv=%0d pending=%03b", a, d, adv, cfg_bus.cfg_pending);
  endtask

  task automatic test_reset();
    reset = 1'b1; pll_locked = 1'b0;
    cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_addr = '0; cfg_bus.cfg_data = '0;
    #3;
    repeat (3) tick();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%0b exp=0", running); end
    checks++; if (ce !== 3'b000) begin errors++; $display("FAIL reset_ce got=%03b exp=000", ce); end
    checks++; if (sq !== 3'b000) begin errors++; $display("FAIL reset_sq got=%03b exp=000", sq); end
    checks++; if (cfg_bus.cfg_pending !== 3'b000) begin errors++; $display("FAIL reset_pending got=%03b exp=000", cfg_bus.cfg_pending); end
    $display("reset: running=%0b ce=%03b sq=%03b", running, ce, sq);
    reset = 1'b0;
  endtask

  // Lock rises now; running must appear on exactly the 18th edge (2 sync + 16 settle).
  task automatic test_settle();
    pll_locked = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      tick();
      checks++; if (running !== (i == 18)) begin errors++; $display("FAIL settle_running edge=%0d got=%0b exp=%0b", i, running, i == 18); end
      checks++; if ({ce, sq} !== 6'b0) begin errors++; $display("FAIL settle_outputs edge=%0d ce=%03b sq=%03b exp=0", i, ce, sq); end
    end
    $display("settle: running=%0b after 18 edges", running);
    adv = 0;
  endtask

  task automatic test_rate();
    int n_ce = 0;
    for (int i = 0; i < 640; i++) begin
      tick();
      checks++; if (ce !== {3{adv % 8 == 0}}) begin errors++; $display("FAIL rate_ce adv=%0d got=%03b exp=%03b", adv, ce, {3{adv % 8 == 0}}); end
      checks++; if (sq !== {3{adv % 8 >= 4}}) begin errors++; $display("FAIL rate_sq adv=%0d got=%03b exp=%03b", adv, sq, {3{adv % 8 >= 4}}); end
      if (ce[0]) n_ce++;
    end
    checks++; if (n_ce != 80) begin errors++; $display("FAIL rate_count got=%0d exp=80", n_ce); end
    $display("rate: %0d strobes on ch0 in 640 cycles", n_ce);
  endtask

  // ch0 retuned to 0x400000 mid-period: old rate holds until the wrap at adv 648.
  task automatic test_retune();
    repeat (3) tick();
    cfg_write(2'd0, 24'h400000);
    checks++; if (cfg_bus.cfg_pending !== 3'b001) begin errors++; $display("FAIL retune_pending_set got=%03b exp=001", cfg_bus.cfg_pending); end
    while (adv < 664) begin
      logic e_ce, e_sq;
      tick();
      e_ce = (adv < 648) ? (adv % 8 == 0) : (adv % 4 == 0);
      e_sq = (adv < 648) ? (adv % 8 >= 4) : (adv % 4 >= 2);
      checks++; if (ce[0] !== e_ce) begin errors++; $display("FAIL retune_ce0 adv=%0d got=%0b exp=%0b", adv, ce[0], e_ce); end
      checks++; if (sq[0] !== e_sq) begin errors++; $display("FAIL retune_sq0 adv=%0d got=%0b exp=%0b", adv, sq[0], e_sq); end
      checks++; if (cfg_bus.cfg_pending[0] !== (adv < 648)) begin errors++; $display("FAIL retune_pending adv=%0d got=%0b exp=%0b", adv, cfg_bus.cfg_pending[0], adv < 648); end
      checks++; if (ce[1] !== (adv % 8 == 0)) begin errors++; $display("FAIL retune_ce1 adv=%0d got=%0b exp=%0b", adv, ce[1], adv % 8 == 0); end
    end
    $display("retune: ch0 period now 4, pending=%03b", cfg_bus.cfg_pending);
  endtask

  task automatic test_bad_addr();
    cfg_write(2'd3, 24'h000001);
    checks++; if (cfg_bus.cfg_pending !== 3'b000) begin errors++; $display("FAIL badaddr_pending got=%03b exp=000", cfg_bus.cfg_pending); end
    repeat (16) begin
      logic [2:0] e_ce;
      tick();
      e_ce = {adv % 8 == 0, adv % 8 == 0, adv % 4 == 0};
      checks++; if (ce !== e_ce) begin errors++; $display("FAIL badaddr_ce adv=%0d got=%03b exp=%03b", adv, ce, e_ce); end
    end
    $display("bad_addr: ignored, adv=%0d", adv);
  endtask

  // ch2 stopped via inc=0 at its wrap, then restarted: the restart applies without a wrap.
  task automatic test_zero_inc();
    cfg_write(2'd2, 24'h000000);
    while (adv < 700) begin
      tick();
      checks++; if (ce[2] !== (adv == 688)) begin errors++; $display("FAIL zero_ce2 adv=%0d got=%0b exp=%0b", adv, ce[2], adv == 688); end
      checks++; if (sq[2] !== ((adv < 688) && (adv % 8 >= 4))) begin errors++; $display("FAIL zero_sq2 adv=%0d got=%0b", adv, sq[2]); end
      checks++; if (cfg_bus.cfg_pending[2] !== (adv < 688)) begin errors++; $display("FAIL zero_pending adv=%0d got=%0b exp=%0b", adv, cfg_bus.cfg_pending[2], adv < 688); end
    end
    cfg_write(2'd2, 24'h200000);
    checks++; if (cfg_bus.cfg_pending[2] !== 1'b1) begin errors++; $display("FAIL restart_pending_set got=%0b exp=1", cfg_bus.cfg_pending[2]); end
    tick();
    checks++; if (cfg_bus.cfg_pending[2] !== 1'b0) begin errors++; $display("FAIL restart_pending_clr got=%0b exp=0", cfg_bus.cfg_pending[2]); end
    while (adv < 718) begin
      tick();
      checks++; if (ce[2] !== ((adv - 702) % 8 == 0)) begin errors++; $display("FAIL restart_ce2 adv=%0d got=%0b", adv, ce[2]); end
      checks++; if (sq[2] !== ((adv - 702) % 8 >= 4)) begin errors++; $display("FAIL restart_sq2 adv=%0d got=%0b", adv, sq[2]); end
    end
    $display("zero_inc: ch2 stopped and restarted, adv=%0d", adv);
  endtask

  // ch1 = 0x0B6DB7 from a wrap at acc=0: 4480 adds give exactly 200 strobes, the last on add 4480.
  task automatic test_ratio();
    int n_ce = 0;
    cfg_write(2'd1, 24'h0B6DB7);
    checks++; if (cfg_bus.cfg_pending[1] !== 1'b1) begin errors++; $display("FAIL ratio_pending_set got=%0b exp=1", cfg_bus.cfg_pending[1]); end
    tick();
    checks++; if ({ce[1], cfg_bus.cfg_pending[1]} !== 2'b10) begin errors++; $display("FAIL ratio_swap ce1=%0b pending1=%0b exp ce1=1 pending1=0", ce[1], cfg_bus.cfg_pending[1]); end
    for (int i = 1; i <= 4480; i++) begin
      tick();
      if (ce[1]) n_ce++;
      if (i == 4479) begin
        checks++; if (n_ce != 199) begin errors++; $display("FAIL ratio_count_4479 got=%0d exp=199", n_ce); end
      end
    end
    checks++; if (n_ce != 200) begin errors++; $display("FAIL ratio_count_4480 got=%0d exp=200", n_ce); end
    $display("ratio: %0d ch1 strobes in 4480 cycles", n_ce);
  endtask

  task automatic test_lock_loss();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL loss_edge1_running got=%0b exp=1", running); end
    tick();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL loss_edge2_running got=%0b exp=1", running); end
    for (int i = 3; i <= 19; i++) begin
      tick();
      checks++; if (running !== (i == 19)) begin errors++; $display("FAIL loss_running edge=%0d got=%0b exp=%0b", i, running, i == 19); end
      checks++; if ({ce, sq} !== 6'b0) begin errors++; $display("FAIL loss_outputs edge=%0d ce=%03b sq=%03b exp=0", i, ce, sq); end
    end
    adv = 0;
    repeat (24) begin
      logic [2:0] e_ce;
      tick();
      e_ce = {adv % 8 == 0, adv == 23, adv % 4 == 0};
      checks++; if (ce !== e_ce) begin errors++; $display("FAIL relock_ce adv=%0d got=%03b exp=%03b", adv, ce, e_ce); end
      checks++; if (sq[1] !== (adv >= 12 && adv <= 22)) begin errors++; $display("FAIL relock_sq1 adv=%0d got=%0b", adv, sq[1]); end
    end
    $display("lock_loss: relocked, incs retained");
  endtask

  task automatic test_reset_pending();
    cfg_write(2'd2, 24'h100000);
    checks++; if (cfg_bus.cfg_pending[2] !== 1'b1) begin errors++; $display("FAIL rstp_pending_set got=%0b exp=1", cfg_bus.cfg_pending[2]); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({running, ce, sq, cfg_bus.cfg_pending} !== 10'b0) begin errors++; $display("FAIL rstp_async running=%0b ce=%03b sq=%03b pending=%03b exp=0", running, ce, sq, cfg_bus.cfg_pending); end
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      tick();
      checks++; if (running !== (i == 18)) begin errors++; $display("FAIL rstp_running edge=%0d got=%0b exp=%0b", i, running, i == 18); end
    end
    adv = 0;
    repeat (16) begin
      tick();
      checks++; if (ce !== {3{adv % 8 == 0}}) begin errors++; $display("FAIL rstp_ce adv=%0d got=%03b exp=%03b", adv, ce, {3{adv % 8 == 0}}); end
      checks++; if (sq !== {3{adv % 8 >= 4}}) begin errors++; $display("FAIL rstp_sq adv=%0d got=%03b exp=%03b", adv, sq, {3{adv % 8 >= 4}}); end
      checks++; if (cfg_bus.cfg_pending !== 3'b000) begin errors++; $display("FAIL rstp_pending adv=%0d got=%03b exp=000", adv, cfg_bus.cfg_pending); end
    end
    $display("reset_pending: incs back to INIT_INC");
  endtask

  initial begin
    test_reset();
    test_settle();
    test_rate();
    test_retune();
    test_bad_addr();
    test_zero_inc();
    test_ratio();
    test_lock_loss();
    test_reset_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
